// File: rtl/fetch_execute_sequencer.sv
// Multi-cycle fetch/decode/execute controller for a 16-bit accumulator machine.
// Memory reads are synchronous (data returns one cycle after the address);
// the ALU sits outside the block and is driven from AC and mem_rdata.
module fetch_execute_sequencer #(
   parameter logic [11:0] RESET_PC = 12'h000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   input  logic [15:0] mem_rdata,
   output logic [3:0]  alu_opcode,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic [15:0] alu_result,
   output logic [15:0] acc_out,
   output logic [11:0] pc_out,
   output logic        busy,
   output logic        halted
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned OP_W   = 4;

   localparam logic [OP_W-1:0] OP_LOAD  = 4'h0;
   localparam logic [OP_W-1:0] OP_STORE = 4'h1;
   localparam logic [OP_W-1:0] OP_ADD   = 4'h2;
   localparam logic [OP_W-1:0] OP_SUB   = 4'h3;
   localparam logic [OP_W-1:0] OP_AND   = 4'h4;
   localparam logic [OP_W-1:0] OP_OR    = 4'h5;
   localparam logic [OP_W-1:0] OP_XOR   = 4'h6;
   localparam logic [OP_W-1:0] OP_SHL   = 4'h7;
   localparam logic [OP_W-1:0] OP_SHR   = 4'h8;
   localparam logic [OP_W-1:0] OP_JMP   = 4'h9;
   localparam logic [OP_W-1:0] OP_JZ    = 4'hA;
   localparam logic [OP_W-1:0] OP_CLR   = 4'hB;
   localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

   localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
   localparam logic [OP_W-1:0] ALU_AND = 4'b1000;
   localparam logic [OP_W-1:0] ALU_OR  = 4'b1001;
   localparam logic [OP_W-1:0] ALU_XOR = 4'b1010;
   localparam logic [OP_W-1:0] ALU_SHL = 4'b0100;
   localparam logic [OP_W-1:0] ALU_SHR = 4'b0101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MREAD,
      S_MWRITE,
      S_EXEC,
      S_HALTED
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   ac_q, ac_d;
   logic [OP_W-1:0]     ir_op;
   logic [ADDR_W-1:0]   ir_addr;

   assign ir_op   = ir_q[DATA_W-1:DATA_W-OP_W];
   assign ir_addr = ir_q[ADDR_W-1:0];

   assign mem_wdata = ac_q;
   assign alu_a     = ac_q;
   assign alu_b     = mem_rdata;
   assign acc_out   = ac_q;
   assign pc_out    = pc_q;

   // State and architectural registers; reset wins over everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         ac_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ac_q    <= ac_d;
      end
   end

   // Next-state, datapath updates and state-decoded memory/ALU controls.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ac_d       = ac_q;
      mem_addr   = {4'b0, ir_addr};
      mem_we     = 1'b0;
      alu_opcode = ALU_ADD;
      busy       = 1'b1;
      halted     = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy     = 1'b0;
            mem_addr = '0;
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_addr = {4'b0, pc_q};
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            ir_d = mem_rdata;
            pc_d = ADDR_W'(pc_q + 12'd1);
            case (mem_rdata[DATA_W-1:DATA_W-OP_W])
               OP_LOAD, OP_ADD, OP_SUB,
               OP_AND, OP_OR, OP_XOR:  state_d = S_MREAD;
               OP_STORE:               state_d = S_MWRITE;
               OP_HALT:                state_d = S_HALTED;
               default:                state_d = S_EXEC;
            endcase
         end
         S_MREAD: begin
            state_d = S_EXEC;
         end
         S_MWRITE: begin
            mem_we  = 1'b1;
            state_d = S_FETCH;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (ir_op)
               OP_LOAD: ac_d = mem_rdata;
               OP_ADD: begin alu_opcode = ALU_ADD; ac_d = alu_result; end
               OP_SUB: begin alu_opcode = ALU_SUB; ac_d = alu_result; end
               OP_AND: begin alu_opcode = ALU_AND; ac_d = alu_result; end
               OP_OR:  begin alu_opcode = ALU_OR;  ac_d = alu_result; end
               OP_XOR: begin alu_opcode = ALU_XOR; ac_d = alu_result; end
               OP_SHL: begin alu_opcode = ALU_SHL; ac_d = alu_result; end
               OP_SHR: begin alu_opcode = ALU_SHR; ac_d = alu_result; end
               OP_JMP: pc_d = ir_addr;
               OP_JZ:  if (ac_q == '0) pc_d = ir_addr;
               OP_CLR: ac_d = '0;
               default: ;
            endcase
         end
         S_HALTED: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_execute_sequencer.sv
// Bench for fetch_execute_sequencer: synchronous memory and ALU models around
// the DUT, an instruction-level reference model that expands each instruction
// into its expected per-cycle bus activity, and directed programs.
module tb_fetch_execute_sequencer;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result, acc_out;
   logic        mem_we, busy, halted;
   logic [3:0]  alu_opcode;
   logic [11:0] pc_out;

   always #5 clk = ~clk;

   fetch_execute_sequencer #(.RESET_PC(12'h000)) dut (
      .clk(clk), .reset(reset), .start(start),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .acc_out(acc_out), .pc_out(pc_out), .busy(busy), .halted(halted)
   );

   // Program image, device memory and write counter.
   logic [15:0] img   [4096];
   logic [15:0] mem   [4096];
   logic [15:0] rdata;
   logic        load_img = 1'b0;
   int          writes = 0;

   assign mem_rdata = rdata;

   // Synchronous-read memory; the image is copied in while load_img is high.
   always @(posedge clk) begin
      if (load_img) begin
         for (int i = 0; i < 4096; i++) mem[i] <= img[i];
      end else if (mem_we) begin
         mem[mem_addr[11:0]] <= mem_wdata;
         writes <= writes + 1;
      end
      rdata <= mem[mem_addr[11:0]];
   end

   // External ALU; shifts are by one position.
   always_comb begin
      case (alu_opcode)
         4'b0000: alu_result = alu_a + alu_b;
         4'b0001: alu_result = alu_a - alu_b;
         4'b1000: alu_result = alu_a & alu_b;
         4'b1001: alu_result = alu_a | alu_b;
         4'b1010: alu_result = alu_a ^ alu_b;
         4'b0100: alu_result = alu_a << 1;
         4'b0101: alu_result = alu_a >> 1;
         default: alu_result = 16'h0000;
      endcase
   end

   typedef struct packed {
      logic [15:0] addr;
      logic        chk_addr;
      logic        we;
      logic        busy;
      logic        halted;
      logic [11:0] pc;
      logic [15:0] acc;
      logic [3:0]  aluop;
   } rec_t;

   rec_t        exp_q[$];
   logic [15:0] m_mem [4096];
   logic [11:0] m_pc;
   logic [15:0] m_acc;
   bit          m_halted;
   bit          trk = 1'b0;
   logic [11:0] last_pc;
   logic [11:0] pc_hist[$];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic rec_t mk(input logic [15:0] addr, input logic ca, input logic we,
                               input logic b, input logic h, input logic [11:0] pc,
                               input logic [15:0] acc, input logic [3:0] aop);
      rec_t r;
      r.addr = addr; r.chk_addr = ca; r.we = we; r.busy = b; r.halted = h;
      r.pc = pc; r.acc = acc; r.aluop = aop;
      return r;
   endfunction

   function automatic logic [3:0] alu_code(input logic [3:0] op);
      case (op)
         4'h2: return 4'b0000;
         4'h3: return 4'b0001;
         4'h4: return 4'b1000;
         4'h5: return 4'b1001;
         4'h6: return 4'b1010;
         4'h7: return 4'b0100;
         4'h8: return 4'b0101;
         default: return 4'b0000;
      endcase
   endfunction

   // Execute one instruction architecturally and queue its expected cycles.
   task automatic model_next();
      logic [15:0] ins, opnd, acc0;
      logic [3:0]  op;
      logic [11:0] a, p1;
      if (m_halted) begin
         exp_q.push_back(mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, m_pc, m_acc, 4'h0));
         return;
      end
      ins  = m_mem[m_pc];
      op   = ins[15:12];
      a    = ins[11:0];
      p1   = m_pc + 12'd1;
      acc0 = m_acc;
      exp_q.push_back(mk({4'h0, m_pc}, 1'b1, 1'b0, 1'b1, 1'b0, m_pc, acc0, 4'h0));
      exp_q.push_back(mk(16'h0, 1'b0, 1'b0, 1'b1, 1'b0, m_pc, acc0, 4'h0));
      m_pc = p1;
      if (op == 4'hF) begin
         m_halted = 1'b1;
      end else if (op == 4'h1) begin
         exp_q.push_back(mk({4'h0, a}, 1'b1, 1'b1, 1'b1, 1'b0, p1, acc0, 4'h0));
         m_mem[a] = acc0;
      end else begin
         if (op <= 4'h6)
            exp_q.push_back(mk({4'h0, a}, 1'b1, 1'b0, 1'b1, 1'b0, p1, acc0, 4'h0));
         exp_q.push_back(mk(16'h0, 1'b0, 1'b0, 1'b1, 1'b0, p1, acc0, alu_code(op)));
         opnd = m_mem[a];
         case (op)
            4'h0: m_acc = opnd;
            4'h2: m_acc = acc0 + opnd;
            4'h3: m_acc = acc0 - opnd;
            4'h4: m_acc = acc0 & opnd;
            4'h5: m_acc = acc0 | opnd;
            4'h6: m_acc = acc0 ^ opnd;
            4'h7: m_acc = {acc0[14:0], 1'b0};
            4'h8: m_acc = {1'b0, acc0[15:1]};
            4'h9: m_pc = a;
            4'hA: if (acc0 == 16'h0) m_pc = a;
            4'hB: m_acc = 16'h0;
            default: ;
         endcase
      end
   endtask

   task automatic compare_cycle();
      rec_t r;
      if (exp_q.size() == 0) model_next();
      r = exp_q.pop_front();
      if (r.chk_addr) chk("mem_addr", mem_addr, r.addr);
      chk("mem_we", 16'(mem_we), 16'(r.we));
      chk("busy", 16'(busy), 16'(r.busy));
      chk("halted", 16'(halted), 16'(r.halted));
      chk("pc_out", 16'(pc_out), 16'(r.pc));
      chk("acc_out", acc_out, r.acc);
      chk("mem_wdata", mem_wdata, r.acc);
      chk("alu_a", alu_a, r.acc);
      chk("alu_b", alu_b, rdata);
      chk("alu_opcode", 16'(alu_opcode), 16'(r.aluop));
   endtask

   // One clock: compare on the falling edge, return just after the rising edge.
   task automatic step();
      @(negedge clk);
      if (trk) compare_cycle();
      @(posedge clk);
      #1;
      if (trk && pc_out !== last_pc) begin
         pc_hist.push_back(pc_out);
         last_pc = pc_out;
      end
   endtask

   task automatic clear_img();
      for (int i = 0; i < 4096; i++) img[i] = 16'h0000;
   endtask

   // Reset the DUT while copying the image into both memories.
   task automatic do_reset();
      trk      = 1'b0;
      start    = 1'b0;
      reset    = 1'b1;
      load_img = 1'b1;
      for (int i = 0; i < 4096; i++) m_mem[i] = img[i];
      step();
      step();
      reset    = 1'b0;
      load_img = 1'b0;
   endtask

   task automatic launch();
      start = 1'b1;
      step();
      start    = 1'b0;
      m_pc     = 12'h000;
      m_acc    = 16'h0000;
      m_halted = 1'b0;
      exp_q.delete();
      pc_hist.delete();
      last_pc  = pc_out;
      trk      = 1'b1;
   endtask

   task automatic run_halt(input bit toggle, output int n);
      n = 0;
      while (halted !== 1'b1 && n < 400) begin
         step();
         n++;
         if (toggle) start = ((n % 3) == 1);
      end
      start = 1'b0;
      chk("run_reached_halt", 16'(halted), 16'h1);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_busy"}, 16'(busy), 16'h0);
      chk({tag, "_halted"}, 16'(halted), 16'h0);
      chk({tag, "_mem_we"}, 16'(mem_we), 16'h0);
      chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
      chk({tag, "_alu_opcode"}, 16'(alu_opcode), 16'h0);
      chk({tag, "_pc"}, 16'(pc_out), 16'h0000);
      chk({tag, "_acc"}, acc_out, 16'h0000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, w0;
      logic [11:0] exp_h [8];
      reset = 1'b1;
      start = 1'b0;

      // Three-instruction program: 5 + 7 stored to M[12].
      clear_img();
      img[0] = 16'h0010; img[1] = 16'h2011; img[2] = 16'h1012; img[3] = 16'hF000;
      img[16] = 16'h0005; img[17] = 16'h0007;
      do_reset();
      chk_reset_state("reset");
      for (int i = 0; i < 3; i++) step();
      chk("idle_without_start_busy", 16'(busy), 16'h0);
      chk("idle_without_start_pc", 16'(pc_out), 16'h0000);
      launch();
      run_halt(1'b1, n);
      chk("edges_to_halt", 16'(n), 16'd13);
      chk("m12_sum", mem[18], 16'h000C);
      chk("acc_sum", acc_out, 16'h000C);
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 0);
         step();
      end
      start = 1'b0;
      chk("halted_ignores_start", 16'(halted), 16'h1);
      chk("halted_pc_held", 16'(pc_out), 16'h0004);
      chk("halted_not_busy", 16'(busy), 16'h0);

      // SUB underflow, STORE of the result, CLR, LOAD and SHL dropping the MSB.
      clear_img();
      img[0] = 16'h0010; img[1] = 16'h3011; img[2] = 16'h1013; img[3] = 16'hB000;
      img[4] = 16'h0012; img[5] = 16'h7000; img[6] = 16'hF000;
      img[16] = 16'h0003; img[17] = 16'h0005; img[18] = 16'h8001;
      do_reset();
      launch();
      run_halt(1'b1, n);
      chk("sub_wraps", mem[19], 16'hFFFE);
      chk("shl_truncates", acc_out, 16'h0002);
      chk("prog2_halt_pc", 16'(pc_out), 16'h0007);

      // JZ taken with AC=0.
      clear_img();
      img[0] = 16'hA020; img[32] = 16'hF000;
      do_reset();
      launch();
      run_halt(1'b0, n);
      chk("jz_taken_pc", 16'(pc_out), 16'h0021);

      // JZ not taken with AC=1.
      clear_img();
      img[0] = 16'h0010; img[1] = 16'hA020; img[2] = 16'hF000; img[32] = 16'hF000;
      img[16] = 16'h0001;
      do_reset();
      launch();
      run_halt(1'b0, n);
      chk("jz_not_taken_pc", 16'(pc_out), 16'h0003);
      chk("jz_not_taken_acc", acc_out, 16'h0001);

      // JMP to the top of memory, NOP there, PC wraps to 000.
      clear_img();
      img[0] = 16'hA005; img[1] = 16'hF000; img[5] = 16'h0011; img[6] = 16'h9FFF;
      img[4095] = 16'hC000; img[17] = 16'h0001;
      do_reset();
      launch();
      run_halt(1'b0, n);
      exp_h = '{12'h001, 12'h005, 12'h006, 12'h007, 12'hFFF, 12'h000, 12'h001, 12'h002};
      chk("pc_hist_len", 16'(pc_hist.size()), 16'd8);
      for (int i = 0; i < 8; i++)
         if (i < pc_hist.size()) chk($sformatf("pc_hist_%0d", i), 16'(pc_hist[i]), 16'(exp_h[i]));

      // Reset during MREAD of the ADD.
      clear_img();
      img[0] = 16'h0010; img[1] = 16'h2011; img[2] = 16'h1020; img[3] = 16'hF000;
      img[16] = 16'h0005; img[17] = 16'h0007;
      do_reset();
      launch();
      for (int i = 0; i < 6; i++) step();
      chk("pre_reset_mread_addr", mem_addr, 16'h0011);
      trk   = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_reset_state("mread_reset");
      step();
      step();
      chk("mread_reset_stays_idle", 16'(busy), 16'h0);

      // Reset during MWRITE: the write on that edge lands, nothing after it.
      do_reset();
      w0 = writes;
      launch();
      for (int i = 0; i < 10; i++) step();
      chk("pre_reset_mwrite_we", 16'(mem_we), 16'h1);
      trk   = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_reset_state("mwrite_reset");
      for (int i = 0; i < 4; i++) step();
      chk("mwrite_reset_write_count", 16'(writes - w0), 16'd1);
      chk("mwrite_reset_data", mem[32], 16'h000C);
      chk("mwrite_reset_idle", 16'(busy), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_execute_sequencer.md
FETCH_EXECUTE_SEQUENCER -- requirements
Module: fetch_execute_sequencer

Interface
REQ-001 Parameter: RESET_PC, 12'h000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  begin execution; sampled only in IDLE.
REQ-005 mem_addr  out  16  memory address, {4'b0, 12-bit address}.
REQ-006 mem_wdata  out  16  memory write data, always equal to AC.
REQ-007 mem_we  out  1  memory write enable, combinational from state.
REQ-008 mem_rdata  in  16  memory read data, valid one cycle after a read address is presented with mem_we=0.
REQ-009 alu_opcode  out  4  ALU operation code.
REQ-010 alu_a  out  16  ALU operand 1, always AC.
REQ-011 alu_b  out  16  ALU operand 2, always mem_rdata.
REQ-012 alu_result  in  16  combinational ALU result.
REQ-013 acc_out  out  16  accumulator AC.
REQ-014 pc_out  out  12  program counter PC.
REQ-015 busy  out  1  high in any state other than IDLE and HALTED.
REQ-016 halted  out  1  high in HALTED.

Function
REQ-017 Instruction format: [15:12] op, [11:0] A; the block holds PC(12), IR(16) and AC(16) internally.
REQ-018 Ops: 0 LOAD AC<=M[A]; 1 STORE M[A]<=AC; 2 ADD; 3 SUB; 4 AND; 5 OR; 6 XOR; 7 SHL; 8 SHR; 9 JMP PC<=A; A JZ PC<=A if AC==0; B CLR AC<=0; C-E NOP; F HALT.
REQ-019 ALU opcode mapping in EXEC: ADD 0000, SUB 0001, AND 1000, OR 1001, XOR 1010, SHL 0100, SHR 0101; in all other states and ops alu_opcode=0000.
REQ-020 States: IDLE, FETCH, DECODE, MREAD, MWRITE, EXEC, HALTED.
REQ-021 IDLE: mem_addr=0, mem_we=0; start=1 moves to FETCH; otherwise the block stays in IDLE.
REQ-022 FETCH: mem_addr={4'b0,PC}, mem_we=0; moves to DECODE.
REQ-023 DECODE: IR<=mem_rdata and PC<=PC+1 (12-bit, 0xFFF wraps to 0x000); next state is decoded from mem_rdata[15:12].
REQ-024 DECODE next state: ops 0,2-6 -> MREAD; op 1 -> MWRITE; ops 7-E -> EXEC; op F -> HALTED.
REQ-025 MREAD: mem_addr={4'b0,IR[11:0]}, mem_we=0; moves to EXEC.
REQ-026 MWRITE: mem_addr={4'b0,IR[11:0]}, mem_we=1 for exactly one cycle; moves to FETCH.
REQ-027 EXEC: LOAD AC<=mem_rdata; ALU ops and SHL/SHR AC<=alu_result (16-bit, truncating, no flags); JMP, JZ and CLR per REQ-018; NOP no change; moves to FETCH.
REQ-028 Latency in cycles from FETCH to the next FETCH: memory-operand ops 4; STORE 3; register-only, jump and NOP ops 3; HALT reaches HALTED 2 cycles after FETCH.
REQ-029 HALTED: outputs hold their values and mem_we=0; only reset exits; start is ignored.
REQ-030 start is ignored in every state except IDLE.
REQ-031 A JZ or JMP executed in EXEC overrides the increment made in DECODE.

Reset
REQ-032 On a clk edge with reset=1, the block shall set: state=IDLE, PC=RESET_PC, AC=0, IR=0; outputs busy=0, halted=0, mem_we=0, mem_addr=0, alu_opcode=0.
REQ-033 Reset has priority over start and over any in-flight operation; no partial instruction resumes.
REQ-034 If reset is asserted during MWRITE, the write presented on that edge still reaches memory; no further write follows.

Verification
REQ-035 Program M[0]=0010, M[1]=2011, M[2]=1012, M[3]=F000, M[10]=0005, M[11]=0007; pulse start -> M[12]=000C, acc_out=000C, halted=1 on the 13th edge after start is sampled.
REQ-036 AC=0003, SUB with M[A]=0005 -> AC=FFFE; then CLR, LOAD with M[A]=8001, SHL -> AC=0002.
REQ-037 Run JZ 020 with AC=0 -> next fetch at 0x020; run JZ 020 with AC=0001 -> next fetch at PC+1.
REQ-038 Run JMP FFF with a NOP at FFF -> pc_out goes FFF then 000; the next fetch is at mem_addr 0000.
REQ-039 Assert reset during MREAD, then during MWRITE -> next cycle IDLE, pc_out=RESET_PC, acc_out=0, mem_we=0; exactly one write is observed for the MWRITE case.
REQ-040 Toggle start while busy and while HALTED -> no change in state or PC.
